// File: rtl/gcn_pkg.sv
// Shared definitions for the GCN classification stage: default sizes,
// controller state encoding and score/class-index types.
package gcn_pkg;

  // Width helper that never returns zero, so single-entry cases still get a
  // one-bit index.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  localparam int DEF_NUM_NODES         = 6;
  localparam int DEF_DOT_PROD_WIDTH    = 16;
  localparam int DEF_WEIGHT_COLS       = 3;
  localparam int DEF_MEM_RD_LATENCY    = 1;
  localparam int DEF_MAX_ADDRESS_WIDTH = clog2_min1(DEF_WEIGHT_COLS);
  localparam int DEF_ROW_ADDR_WIDTH    = clog2_min1(DEF_NUM_NODES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef logic [DEF_DOT_PROD_WIDTH-1:0]    score_t;
  typedef logic [DEF_MAX_ADDRESS_WIDTH-1:0] class_idx_t;

endpackage

// File: rtl/argmax_controller_if.sv
// Bundle of the start/readback/result signals between the argmax controller
// (master) and its environment: upstream start, product memory, result consumer.
interface argmax_controller_if #(
  parameter int NUM_NODES      = gcn_pkg::DEF_NUM_NODES,
  parameter int DOT_PROD_WIDTH = gcn_pkg::DEF_DOT_PROD_WIDTH,
  parameter int WEIGHT_COLS    = gcn_pkg::DEF_WEIGHT_COLS
) ();
  localparam int MAX_ADDRESS_WIDTH = gcn_pkg::clog2_min1(WEIGHT_COLS);
  localparam int ROW_ADDR_WIDTH    = gcn_pkg::clog2_min1(NUM_NODES);

  logic                         start;
  logic                         read_en;
  logic [ROW_ADDR_WIDTH-1:0]    read_row_addr;
  logic [DOT_PROD_WIDTH-1:0]    read_row_data [0:WEIGHT_COLS-1];
  logic                         busy;
  logic                         done;
  logic [MAX_ADDRESS_WIDTH-1:0] max_addr_out  [0:NUM_NODES-1];

  modport master (
    input  start, read_row_data,
    output read_en, read_row_addr, busy, done, max_addr_out
  );

  modport slave (
    output start, read_row_data,
    input  read_en, read_row_addr, busy, done, max_addr_out
  );
endinterface

// File: rtl/argmax_controller_scan.sv
// Combinational argmax over one row of unsigned class scores. Linear scan
// from index 0 replacing only on strictly greater, so ties go to the lowest index.
module argmax_scan #(
  parameter int WEIGHT_COLS    = gcn_pkg::DEF_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH = gcn_pkg::DEF_DOT_PROD_WIDTH,
  parameter int IDX_WIDTH      = gcn_pkg::clog2_min1(WEIGHT_COLS)
) (
  input  logic [DOT_PROD_WIDTH-1:0] row [0:WEIGHT_COLS-1],
  output logic [IDX_WIDTH-1:0]      idx
);
  logic [DOT_PROD_WIDTH-1:0] w_best;
  logic                      w_gt;

  // Running maximum; the index moves only when a later score is strictly larger.
  always_comb begin
    w_best = row[0];
    idx    = IDX_WIDTH'(0);
    w_gt   = 1'b0;
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      w_gt   = (row[c] > w_best);
      idx    = w_gt ? IDX_WIDTH'(c) : idx;
      w_best = w_gt ? row[c] : w_best;
    end
  end
endmodule

// File: rtl/argmax_controller.sv
// Final GCN classification sequencer: on a rising start edge it reads each
// product-memory row, stores the argmax class index per node and raises done.
module argmax_controller
  import gcn_pkg::*;
#(
  parameter int NUM_NODES      = DEF_NUM_NODES,
  parameter int DOT_PROD_WIDTH = DEF_DOT_PROD_WIDTH,
  parameter int WEIGHT_COLS    = DEF_WEIGHT_COLS,
  parameter int MEM_RD_LATENCY = DEF_MEM_RD_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  argmax_controller_if.master bus
);
  localparam int MAX_ADDRESS_WIDTH = clog2_min1(WEIGHT_COLS);
  localparam int ROW_ADDR_WIDTH    = clog2_min1(NUM_NODES);
  localparam int WAIT_CNT_WIDTH    = clog2_min1(MEM_RD_LATENCY);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [ROW_ADDR_WIDTH-1:0]    r_row;
  logic [ROW_ADDR_WIDTH-1:0]    w_next_row;
  logic [WAIT_CNT_WIDTH-1:0]    r_wait_cnt;
  logic                         r_start_d;
  logic                         r_read_en;
  logic [ROW_ADDR_WIDTH-1:0]    r_read_addr;
  logic                         r_busy;
  logic                         r_done;
  logic [MAX_ADDRESS_WIDTH-1:0] r_max [0:NUM_NODES-1];
  logic [MAX_ADDRESS_WIDTH-1:0] w_idx;
  logic                         w_launch;
  logic                         w_last_row;

  assign w_launch   = bus.start & ~r_start_d;
  assign w_last_row = (r_row == ROW_ADDR_WIDTH'(NUM_NODES - 1));

  argmax_scan #(
    .WEIGHT_COLS    (WEIGHT_COLS),
    .DOT_PROD_WIDTH (DOT_PROD_WIDTH),
    .IDX_WIDTH      (MAX_ADDRESS_WIDTH)
  ) u_scan (
    .row (bus.read_row_data),
    .idx (w_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and next row; launches are honoured only while idle or done.
  always_comb begin
    w_next_state = r_state;
    w_next_row   = r_row;
    case (r_state)
      IDLE, DONE: begin
        if (w_launch) begin
          w_next_state = FETCH;
          w_next_row   = ROW_ADDR_WIDTH'(0);
        end else begin
          w_next_state = r_state;
        end
      end
      FETCH: w_next_state = WAIT;
      WAIT: begin
        if (r_wait_cnt == WAIT_CNT_WIDTH'(0)) begin
          w_next_state = CAPTURE;
        end else begin
          w_next_state = WAIT;
        end
      end
      CAPTURE: begin
        if (w_last_row) begin
          w_next_state = DONE;
        end else begin
          w_next_state = FETCH;
          w_next_row   = r_row + ROW_ADDR_WIDTH'(1);
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: start edge history, registered read strobe/address, wait
  // countdown, per-node results and the busy/done flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_d   <= 1'b0;
      r_read_en   <= 1'b0;
      r_read_addr <= ROW_ADDR_WIDTH'(0);
      r_row       <= ROW_ADDR_WIDTH'(0);
      r_wait_cnt  <= WAIT_CNT_WIDTH'(0);
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) begin
        r_max[n] <= MAX_ADDRESS_WIDTH'(0);
      end
    end else begin
      r_start_d <= bus.start;
      r_row     <= w_next_row;
      // Strobe is high for exactly the FETCH cycle; the address then holds.
      r_read_en <= (w_next_state == FETCH);
      if (w_next_state == FETCH) begin
        r_read_addr <= w_next_row;
      end else begin
        r_read_addr <= r_read_addr;
      end
      case (r_state)
        IDLE, DONE: begin
          if (w_launch) begin
            r_done <= 1'b0;
            r_busy <= 1'b1;
          end else begin
            r_done <= r_done;
          end
        end
        FETCH: r_wait_cnt <= WAIT_CNT_WIDTH'(MEM_RD_LATENCY - 1);
        WAIT: begin
          if (r_wait_cnt != WAIT_CNT_WIDTH'(0)) begin
            r_wait_cnt <= r_wait_cnt - WAIT_CNT_WIDTH'(1);
          end else begin
            r_wait_cnt <= r_wait_cnt;
          end
        end
        CAPTURE: begin
          r_max[r_row] <= w_idx;
          if (w_last_row) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.read_en       = r_read_en;
  assign bus.read_row_addr = r_read_addr;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.max_addr_out  = r_max;

endmodule

// File: tb/tb_argmax_controller.sv
// Directed bench for argmax_controller: one latency-1 and one latency-3
// instance, each fed by a small product-memory model that drives X outside
// the data-valid window.
module tb_argmax_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  argmax_controller_if #(.NUM_NODES(6), .DOT_PROD_WIDTH(16), .WEIGHT_COLS(3)) bus1 ();
  argmax_controller_if #(.NUM_NODES(6), .DOT_PROD_WIDTH(16), .WEIGHT_COLS(3)) bus3 ();

  argmax_controller #(.NUM_NODES(6), .DOT_PROD_WIDTH(16), .WEIGHT_COLS(3), .MEM_RD_LATENCY(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.master));
  argmax_controller #(.NUM_NODES(6), .DOT_PROD_WIDTH(16), .WEIGHT_COLS(3), .MEM_RD_LATENCY(3))
    dut3 (.clk(clk), .reset(reset), .bus(bus3.master));

  logic [15:0] mem [0:5][0:2];
  logic [3:0]  h1 = 4'd0;
  logic [3:0]  h3 = 4'd0;
  logic [2:0]  a1 = 3'd0;
  logic [2:0]  a3 = 3'd0;
  int          rc1 = 0;
  int          rc3 = 0;

  // Memory model: remembers read strobes and addresses, counts strobes.
  always @(posedge clk) begin
    h1 <= {h1[2:0], bus1.read_en};
    h3 <= {h3[2:0], bus3.read_en};
    if (bus1.read_en) begin
      a1  <= bus1.read_row_addr;
      rc1 <= rc1 + 1;
    end
    if (bus3.read_en) begin
      a3  <= bus3.read_row_addr;
      rc3 <= rc3 + 1;
    end
  end

  // Row data valid from LATENCY cycles after the strobe cycle for two cycles, X otherwise.
  for (genvar c = 0; c < 3; c++) begin : g_rd
    assign bus1.read_row_data[c] = (h1[0] | h1[1]) ? mem[a1][c] : 16'hxxxx;
    assign bus3.read_row_data[c] = (h3[2] | h3[3]) ? mem[a3][c] : 16'hxxxx;
  end

  task automatic set_row(input int r, input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
    mem[r][0] = s0;
    mem[r][1] = s1;
    mem[r][2] = s2;
  endtask

  task automatic load_basic();
    set_row(0, 16'd1, 16'd9, 16'd3);
    set_row(1, 16'd8, 16'd2, 16'd2);
    set_row(2, 16'd0, 16'd0, 16'd7);
    set_row(3, 16'd4, 16'd6, 16'd5);
    set_row(4, 16'd3, 16'd3, 16'd3);
    set_row(5, 16'd10, 16'd1, 16'd10);
  endtask

  // Low-then-high start edge; reports done just after the launch edge and the
  // number of cycles until done rises (bounded).
  task automatic run_pass(input bit use3, output int cycles, output logic done_p0);
    @(negedge clk);
    if (use3) bus3.start = 1'b0; else bus1.start = 1'b0;
    @(negedge clk);
    if (use3) bus3.start = 1'b1; else bus1.start = 1'b1;
    @(posedge clk);
    #1;
    done_p0 = use3 ? bus3.done : bus1.done;
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      #1;
    end while (!(use3 ? bus3.done : bus1.done) && cycles < 60);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus1.done, bus1.busy, bus1.read_en} !== 3'b000) $display("FAIL reset_flags1: got %b expected 000", {bus1.done, bus1.busy, bus1.read_en});
    else n_pass++;
    n_checks++;
    if ({bus3.done, bus3.busy, bus3.read_en} !== 3'b000) $display("FAIL reset_flags3: got %b expected 000", {bus3.done, bus3.busy, bus3.read_en});
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus1.max_addr_out[i] !== 2'd0) $display("FAIL reset_max[%0d]: got %0d expected 0", i, bus1.max_addr_out[i]);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [1:0] exp [0:5];
    int cyc;
    logic d0;
    int snap;
    exp = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0};
    load_basic();
    snap = rc1;
    run_pass(1'b0, cyc, d0);
    n_checks++;
    if (cyc !== 18) $display("FAIL basic_latency: got %0d cycles expected 18", cyc);
    else n_pass++;
    n_checks++;
    if (bus1.busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", bus1.busy);
    else n_pass++;
    n_checks++;
    if (rc1 - snap !== 6) $display("FAIL basic_reads: got %0d expected 6", rc1 - snap);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus1.max_addr_out[i] !== exp[i]) $display("FAIL basic_max[%0d]: got %0d expected %0d", i, bus1.max_addr_out[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ties();
    logic [1:0] exp [0:5];
    int cyc;
    logic d0;
    exp = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    set_row(0, 16'hFFFF, 16'hFFFF, 16'h0000);
    set_row(1, 16'h0000, 16'h0000, 16'h0000);
    set_row(2, 16'h0000, 16'hFFFF, 16'hFFFF);
    set_row(3, 16'h0000, 16'h0000, 16'hFFFF);
    set_row(4, 16'd5, 16'd5, 16'd3);
    set_row(5, 16'd2, 16'd7, 16'd7);
    run_pass(1'b0, cyc, d0);
    n_checks++;
    if (cyc !== 18) $display("FAIL ties_latency: got %0d cycles expected 18", cyc);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus1.max_addr_out[i] !== exp[i]) $display("FAIL ties_max[%0d]: got %0d expected %0d", i, bus1.max_addr_out[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_retrigger();
    int snap;
    int cyc;
    logic d0;
    // start still high from the previous pass: no relaunch
    snap = rc1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (rc1 - snap !== 0 || bus1.done !== 1'b1) $display("FAIL held_start: got reads %0d done %b expected 0 and 1", rc1 - snap, bus1.done);
    else n_pass++;
    // mid-pass edge and an edge on the last CAPTURE are both ignored
    load_basic();
    @(negedge clk);
    bus1.start = 1'b0;
    @(negedge clk);
    bus1.start = 1'b1;
    snap = rc1;
    @(posedge clk);
    for (int i = 1; i <= 28; i++) begin
      @(posedge clk);
      #1;
      if (i == 17) begin
        n_checks++;
        if (bus1.done !== 1'b0) $display("FAIL pulse_early_done: got %b expected 0", bus1.done);
        else n_pass++;
      end
      if (i == 18) begin
        n_checks++;
        if (bus1.done !== 1'b1) $display("FAIL pulse_done18: got %b expected 1", bus1.done);
        else n_pass++;
      end
      if (i == 5 || i == 9) bus1.start = 1'b0;
      if (i == 7 || i == 17) bus1.start = 1'b1;
    end
    n_checks++;
    if (rc1 - snap !== 6) $display("FAIL pulse_reads: got %0d expected 6", rc1 - snap);
    else n_pass++;
    n_checks++;
    if (bus1.done !== 1'b1 || bus1.busy !== 1'b0) $display("FAIL pulse_final: got done %b busy %b expected 1 0", bus1.done, bus1.busy);
    else n_pass++;
    // toggle in DONE launches a new pass
    run_pass(1'b0, cyc, d0);
    n_checks++;
    if (d0 !== 1'b0) $display("FAIL relaunch_done_clear: got %b expected 0", d0);
    else n_pass++;
    n_checks++;
    if (cyc !== 18) $display("FAIL relaunch_latency: got %0d cycles expected 18", cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp [0:5];
    int cyc;
    logic d0;
    int snap;
    exp = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0};
    @(negedge clk);
    bus1.start = 1'b0;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus1.done, bus1.busy, bus1.read_en} !== 3'b000 || bus1.read_row_addr !== 3'd0)
      $display("FAIL midreset_flags: got %b addr %0d expected 000 addr 0", {bus1.done, bus1.busy, bus1.read_en}, bus1.read_row_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus1.max_addr_out[i] !== 2'd0) $display("FAIL midreset_max[%0d]: got %0d expected 0", i, bus1.max_addr_out[i]);
      else n_pass++;
    end
    bus1.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    snap = rc1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (bus1.done !== 1'b0 || rc1 - snap !== 0) $display("FAIL midreset_idle: got done %b reads %0d expected 0 0", bus1.done, rc1 - snap);
    else n_pass++;
    run_pass(1'b0, cyc, d0);
    n_checks++;
    if (cyc !== 18) $display("FAIL midreset_latency: got %0d cycles expected 18", cyc);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus1.max_addr_out[i] !== exp[i]) $display("FAIL midreset_max_after[%0d]: got %0d expected %0d", i, bus1.max_addr_out[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_latency3();
    logic [1:0] exp [0:5];
    int cyc;
    logic d0;
    int snap;
    exp = '{2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0};
    load_basic();
    snap = rc3;
    run_pass(1'b1, cyc, d0);
    n_checks++;
    if (cyc !== 30) $display("FAIL lat3_latency: got %0d cycles expected 30", cyc);
    else n_pass++;
    n_checks++;
    if (rc3 - snap !== 6) $display("FAIL lat3_reads: got %0d expected 6", rc3 - snap);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus3.max_addr_out[i] !== exp[i] || $isunknown(bus3.max_addr_out[i]))
        $display("FAIL lat3_max[%0d]: got %0d expected %0d", i, bus3.max_addr_out[i], exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    test_reset();
    test_basic();
    test_ties();
    test_retrigger();
    test_reset_mid();
    test_latency3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
